// File: rtl/if_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_fetch_queue: sequential fetch with DEPTH-entry decoupling FIFO.      |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module if_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      redirect,
   input  logic [XLEN-1:0]           redirect_pc,
   output logic                      imem_req,
   output logic [XLEN-1:0]           imem_addr,
   input  logic                      imem_hit,
   input  logic [XLEN-1:0]           imem_data,
   output logic                      out_valid,
   output logic [XLEN-1:0]           out_inst,
   output logic [XLEN-1:0]           out_pc,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    count,
   output logic [CNT_W-1:0]          miss_cycles,
   output logic [CNT_W-1:0]          fetched
);

   localparam int PTR_W    = $clog2(DEPTH);
   localparam int CNT_BITS = PTR_W + 1;

   logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_BITS-1:0] count_q, count_d;
   logic [CNT_W-1:0]    miss_q, miss_d;
   logic [CNT_W-1:0]    fetched_q, fetched_d;
   logic [XLEN-1:0]     inst_mem_q [DEPTH];
   logic [XLEN-1:0]     inst_mem_d [DEPTH];
   logic [XLEN-1:0]     pc_mem_q   [DEPTH];
   logic [XLEN-1:0]     pc_mem_d   [DEPTH];

   logic full, req, push, miss, pop;
   logic unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];

   always_comb begin
      full     = (count_q == CNT_BITS'(DEPTH));
      req      = !full && !redirect && !rst;
      push     = req && imem_hit;
      miss     = req && !imem_hit;
      // A redirect squashes the same-cycle pop so the flush leaves an empty queue.
      pop      = (count_q != '0) && out_ready && !redirect;

      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      inst_mem_d = inst_mem_q;
      pc_mem_d   = pc_mem_q;
      miss_d     = miss_q;
      fetched_d  = fetched_q;

      if (miss && (miss_q != '1)) begin
         miss_d = miss_q + CNT_W'(1);
      end
      if (push && (fetched_q != '1)) begin
         fetched_d = fetched_q + CNT_W'(1);
      end
      if (push) begin
         inst_mem_d[wr_ptr_q] = imem_data;
         pc_mem_d[wr_ptr_q]   = fetch_pc_q;
      end

      if (redirect) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         miss_q     <= '0;
         fetched_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         miss_q     <= miss_d;
         fetched_q  <= fetched_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
   end

   assign imem_req    = req;
   assign imem_addr   = fetch_pc_q;
   assign out_valid   = (count_q != '0);
   assign out_inst    = inst_mem_q[rd_ptr_q];
   assign out_pc      = pc_mem_q[rd_ptr_q];
   assign count       = count_q;
   assign miss_cycles = miss_q;
   assign fetched     = fetched_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_if_fetch_queue: scoreboard bench for if_fetch_queue.                 |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_if_fetch_queue;
   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam int          CNT_W    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] KEY      = 32'hDEAD_BEEF;

   logic clk, rst, redirect, imem_req, imem_hit, out_valid, out_ready;
   logic [31:0] redirect_pc, imem_addr, imem_data, out_inst, out_pc;
   logic [2:0]  count;
   logic [3:0]  miss_cycles, fetched;

   if_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_hit(imem_hit), .imem_data(imem_data),
      .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready),
      .count(count), .miss_cycles(miss_cycles), .fetched(fetched)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   assign imem_data = imem_addr ^ KEY;

   // Reference model of fetch PC, occupancy and counters.
   logic [31:0] m_pc;
   logic [2:0]  m_cnt;
   logic [3:0]  m_miss, m_fetched;
   logic        mdl_req, obs_req;
   logic [31:0] mdl_addr, obs_addr;
   logic [63:0] exp_q [$];
   logic [64:0] want_q [$];
   logic [64:0] got_q [$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic tick();
      logic m_push, m_pop;
      #1;
      mdl_req  = (m_cnt != 3'(DEPTH)) && !redirect && !rst;
      mdl_addr = m_pc;
      obs_req  = imem_req;
      obs_addr = imem_addr;
      m_push   = mdl_req && imem_hit;
      m_pop    = (m_cnt != 3'd0) && out_ready && !redirect && !rst;
      if (m_pop) begin
         want_q.push_back({1'b1, exp_q.pop_front()});
         got_q.push_back({out_valid, out_pc, out_inst});
      end
      if (m_push) exp_q.push_back({m_pc, m_pc ^ KEY});
      if (mdl_req && !imem_hit && m_miss != 4'hF) m_miss = m_miss + 4'd1;
      if (m_push && m_fetched != 4'hF) m_fetched = m_fetched + 4'd1;
      if (rst) begin
         m_pc = RESET_PC; m_cnt = 3'd0; m_miss = 4'd0; m_fetched = 4'd0;
         exp_q.delete();
      end else if (redirect) begin
         m_pc = {redirect_pc[31:2], 2'b00}; m_cnt = 3'd0;
         exp_q.delete();
      end else begin
         if (m_push) m_pc = m_pc + 32'd4;
         m_cnt = m_cnt + 3'(m_push) - 3'(m_pop);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect = 1'b0; imem_hit = 1'b0; out_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_hit = 1'b1; out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
      tick();
      tick();
      n_checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== RESET_PC || obs_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state count=%0d valid=%b addr=%h req=%b want 0 0 %h 0", count, out_valid, imem_addr, obs_req, RESET_PC);
      end
      n_checks++;
      if (miss_cycles !== 4'd0 || fetched !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_counters miss=%0d fetched=%0d want 0 0", miss_cycles, fetched);
      end
      rst = 1'b0; redirect = 1'b0; imem_hit = 1'b0; out_ready = 1'b0;
      #1;
      n_checks++;
      if (imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_req got %b want 1", imem_req);
      end
   endtask

   task automatic test_stream();
      logic [64:0] g, w;
      do_reset();
      imem_hit = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++;
         if (obs_req !== mdl_req || obs_addr !== mdl_addr || count !== 3'd1 || out_valid !== 1'b1 || out_pc !== mdl_addr) begin
            n_fail++;
            $display("FAIL stream cyc=%0d req=%b addr=%h count=%0d valid=%b out_pc=%h want 1 %h 1 1 %h",
                     i, obs_req, obs_addr, count, out_valid, out_pc, mdl_addr, mdl_addr);
         end
      end
      while (got_q.size() > 0) begin
         g = got_q.pop_front(); w = want_q.pop_front(); n_checks++;
         if (g !== w) begin n_fail++; $display("FAIL stream_sb got %h want %h", g, w); end
      end
   endtask

   task automatic test_freeze_full();
      logic [64:0] g, w;
      do_reset();
      imem_hit = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if (obs_req !== mdl_req || obs_addr !== mdl_addr) begin
            n_fail++;
            $display("FAIL freeze_req cyc=%0d req=%b addr=%h want %b %h", i, obs_req, obs_addr, mdl_req, mdl_addr);
         end
      end
      n_checks++;
      if (count !== 3'd4 || imem_req !== 1'b0 || out_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL full_state count=%0d req=%b out_pc=%h want 4 0 0", count, imem_req, out_pc);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (obs_req !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10 || count !== 3'd3) begin
         n_fail++;
         $display("FAIL full_resume pop_req=%b req=%b addr=%h count=%0d want 0 1 10 3", obs_req, imem_req, imem_addr, count);
      end
      imem_hit = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      while (got_q.size() > 0) begin
         g = got_q.pop_front(); w = want_q.pop_front(); n_checks++;
         if (g !== w) begin n_fail++; $display("FAIL freeze_sb got %h want %h", g, w); end
      end
   endtask

   task automatic test_miss();
      logic [64:0] g, w;
      do_reset();
      redirect = 1'b1; redirect_pc = 32'h20; imem_hit = 1'b1; out_ready = 1'b1;
      tick();
      redirect = 1'b0; imem_hit = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if (imem_addr !== 32'h20 || miss_cycles !== 4'd3 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL miss_hold addr=%h miss=%0d count=%0d want 20 3 0", imem_addr, miss_cycles, count);
      end
      imem_hit = 1'b1;
      tick();
      imem_hit = 1'b0;
      n_checks++;
      if (imem_addr !== 32'h24 || out_pc !== 32'h20 || count !== 3'd1 || fetched !== m_fetched) begin
         n_fail++;
         $display("FAIL miss_push addr=%h out_pc=%h count=%0d fetched=%0d want 24 20 1 %0d", imem_addr, out_pc, count, fetched, m_fetched);
      end
      for (int i = 0; i < 3; i++) tick();
      while (got_q.size() > 0) begin
         g = got_q.pop_front(); w = want_q.pop_front(); n_checks++;
         if (g !== w) begin n_fail++; $display("FAIL miss_sb got %h want %h", g, w); end
      end
   endtask

   task automatic test_redirect();
      logic [64:0] g, w;
      logic [3:0]  f0;
      do_reset();
      imem_hit = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if (count !== 3'd3) begin n_fail++; $display("FAIL redir_fill count=%0d want 3", count); end
      f0 = fetched;
      redirect = 1'b1; redirect_pc = 32'h103; out_ready = 1'b1;
      tick();
      redirect = 1'b0;
      n_checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'h100 || fetched !== f0 || obs_req !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_flush count=%0d valid=%b addr=%h fetched=%0d req=%b want 0 0 100 %0d 0",
                  count, out_valid, imem_addr, fetched, obs_req, f0);
      end
      #1;
      n_checks++;
      if (imem_req !== 1'b1) begin n_fail++; $display("FAIL redir_req got %b want 1", imem_req); end
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (out_pc !== 32'h10C) begin n_fail++; $display("FAIL redir_head out_pc=%h want 10c", out_pc); end
      while (got_q.size() > 0) begin
         g = got_q.pop_front(); w = want_q.pop_front(); n_checks++;
         if (g !== w) begin n_fail++; $display("FAIL redir_sb got %h want %h", g, w); end
      end
   endtask

   task automatic test_wrap();
      logic [64:0] g, w;
      logic [31:0] hit_pat, rdy_pat;
      int seen_zero, pops;
      hit_pat = 32'b1101_1011_0111_1110_1101_1011_1011_0111;
      rdy_pat = 32'b1011_0110_1101_1100_1110_1011_0101_1101;
      seen_zero = 0;
      do_reset();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF0;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 28; i++) begin
         imem_hit = hit_pat[i]; out_ready = rdy_pat[i];
         tick();
         if (obs_addr === 32'h0) seen_zero = 1;
         n_checks++;
         if (obs_req !== mdl_req || obs_addr !== mdl_addr || count !== m_cnt) begin
            n_fail++;
            $display("FAIL wrap_cyc cyc=%0d req=%b addr=%h count=%0d want %b %h %0d", i, obs_req, obs_addr, count, mdl_req, mdl_addr, m_cnt);
         end
      end
      imem_hit = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      pops = got_q.size();
      n_checks++;
      if (pops < 10 || seen_zero == 0) begin
         n_fail++;
         $display("FAIL wrap_cover pops=%0d seen_zero=%0d want >=10 1", pops, seen_zero);
      end
      while (got_q.size() > 0) begin
         g = got_q.pop_front(); w = want_q.pop_front(); n_checks++;
         if (g !== w) begin n_fail++; $display("FAIL wrap_sb got %h want %h", g, w); end
      end
   endtask

   task automatic test_rst_mid();
      do_reset();
      imem_hit = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1; imem_hit = 1'b0;
      tick();
      rst = 1'b0;
      n_checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== RESET_PC || fetched !== 4'd0 || miss_cycles !== 4'd0) begin
         n_fail++;
         $display("FAIL rst_full count=%0d valid=%b addr=%h fetched=%0d miss=%0d want 0 0 0 0 0",
                  count, out_valid, imem_addr, fetched, miss_cycles);
      end
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect = 1'b0; imem_hit = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      n_checks++;
      if (miss_cycles !== 4'd2 || imem_addr !== 32'h40) begin
         n_fail++;
         $display("FAIL rst_pre_miss miss=%0d addr=%h want 2 40", miss_cycles, imem_addr);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (count !== 3'd0 || imem_addr !== RESET_PC || miss_cycles !== 4'd0 || fetched !== 4'd0) begin
         n_fail++;
         $display("FAIL rst_miss count=%0d addr=%h miss=%0d fetched=%0d want 0 0 0 0", count, imem_addr, miss_cycles, fetched);
      end
      got_q.delete(); want_q.delete();
   endtask

   task automatic test_saturation();
      logic [64:0] g, w;
      do_reset();
      imem_hit = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      n_checks++;
      if (fetched !== 4'd15 || fetched !== m_fetched) begin
         n_fail++; $display("FAIL sat_fetched got %0d want 15", fetched);
      end
      imem_hit = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      n_checks++;
      if (miss_cycles !== 4'd15 || fetched !== 4'd15) begin
         n_fail++; $display("FAIL sat_miss miss=%0d fetched=%0d want 15 15", miss_cycles, fetched);
      end
      while (got_q.size() > 0) begin
         g = got_q.pop_front(); w = want_q.pop_front(); n_checks++;
         if (g !== w) begin n_fail++; $display("FAIL sat_sb got %h want %h", g, w); end
      end
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_hit = 1'b0; out_ready = 1'b0;
      test_reset();
      test_stream();
      test_freeze_full();
      test_miss();
      test_redirect();
      test_wrap();
      test_rst_mid();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised successor to the single-register instruction-fetch stage. It generates sequential fetch addresses, issues them to the instruction cache, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode consumes from the FIFO under a valid/ready handshake, so cache misses and decode freezes are decoupled. Control-flow redirects from later stages (branch, jump, jr target already resolved) flush the FIFO and restart fetch.

Parameters:
XLEN, 32, width of PC and instruction word
DEPTH, 4, fetch FIFO entries; power of two, >= 2
RESET_PC, 0, fetch PC after reset; must be a multiple of 4
CNT_W, 32, width of the saturating performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
redirect  in  1  take redirect_pc this cycle; flushes the FIFO
redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored and forced to 0
imem_req  out  1  fetch request valid this cycle
imem_addr  out  XLEN  fetch address (current fetch PC)
imem_hit  in  1  instruction cache hit for imem_addr, same cycle
imem_data  in  XLEN  instruction word; valid only when imem_hit=1
out_valid  out  1  FIFO head holds a valid instruction
out_inst  out  XLEN  head instruction
out_pc  out  XLEN  PC of the head instruction
out_ready  in  1  decode accepts the head this cycle (driven as !freeze)
count  out  $clog2(DEPTH)+1  current FIFO occupancy
miss_cycles  out  CNT_W  cycles with imem_req=1 and imem_hit=0; saturating
fetched  out  CNT_W  number of instructions pushed; saturating

Behaviour:
- Reset (rst=1 at a clock edge): fetch_pc=RESET_PC; FIFO empty (count=0, rd_ptr=wr_ptr=0); out_valid=0; miss_cycles=0; fetched=0. Reset overrides redirect and all other inputs. Asserting rst mid-miss or with a full FIFO discards all contents.
- Outputs: imem_addr=fetch_pc at all times. imem_req = !full && !redirect && !rst, where full = (count==DEPTH).
- Push: when imem_req && imem_hit, write {fetch_pc, imem_data} at wr_ptr, advance wr_ptr, and set fetch_pc <= fetch_pc+4. fetch_pc wraps modulo 2^XLEN.
- Miss: when imem_req && !imem_hit, fetch_pc holds, nothing is pushed, and miss_cycles increments.
- Pop: when out_valid && out_ready, advance rd_ptr. Pointers wrap modulo DEPTH.
- out_valid=(count!=0). out_inst and out_pc come from the entry at rd_ptr. They are registered and must not depend combinationally on out_ready or imem_*.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full FIFO: no request is issued even if a pop occurs in the same cycle. There is no combinational path from out_ready to imem_req. Fetch resumes the cycle after count drops below DEPTH.
- Empty FIFO: out_ready is ignored and no pop occurs. An instruction pushed in cycle N is visible at the head in cycle N+1 (1-cycle fetch-to-decode latency).
- Redirect (takes priority over push and pop):
  - count <= 0, rd_ptr=wr_ptr=0.
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - Any same-cycle hit is dropped, any same-cycle pop is ignored, and fetched does not increment.
  - The first request to the new target is issued in the cycle after the redirect.
- Counters saturate at all-ones and never wrap. fetched increments once per push.
- Freeze (out_ready=0) never stops fetching. Fetching continues until the FIFO is full.

Test Plan:
- Reset, then imem_hit=1 constantly, out_ready=1 → imem_addr runs 0,4,8,…; out_valid goes high 1 cycle after the first request; out_pc trails imem_addr by 1 cycle; count stays 1.
- out_ready=0, hits continuous, DEPTH=4 → pushes from PCs 0,4,8,12; count=4; imem_req=0 from cycle 5 on; on the first out_ready=1, out_pc=0 and imem_req returns 1 the following cycle with imem_addr=16.
- Miss: imem_hit=0 for 3 cycles at PC 0x20 → imem_addr holds 0x20; miss_cycles +3; the next hit pushes PC 0x20 exactly once.
- Redirect with count=3 and a simultaneous hit and pop, redirect_pc=0x103 → next cycle count=0, out_valid=0, imem_addr=0x100; the dropped instruction never appears at out_pc.
- Wrap: 10 push/pop pairs interleaved with stalls, DEPTH=4 → out_pc sequence is strictly consecutive by 4 with no loss or duplication; fetch_pc wraps 0xFFFFFFFC→0.
- Assert rst while full and mid-miss → one cycle later count=0, imem_addr=RESET_PC, counters=0. Counter saturation is tested with CNT_W=4 → fetched stops at 15.
